// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline constants: datapath widths, ALU operation encodings
// and forwarding-select codes used by the execute stage.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Code 2'b11 is not listed here; the muxes treat it as FWD_RF.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: add/sub/and/or/signed slt with a zero flag.
// Unlisted operation codes produce zero.
module alu
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic w_lt;

  assign w_lt = ($signed(SrcA) < $signed(SrcB));

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, w_lt};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, BEQ resolution, branch target and
// the EX/MEM register. Forwarding muxes exist only when EXEC_FORWARD_EN is defined.
module execute_cycle
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_zero;

  logic            r_reg_write_m;
  logic            r_mem_write_m;
  logic            r_result_src_m;
  logic [REGW-1:0] r_rd_m;
  logic [XLEN-1:0] r_alu_result_m;
  logic [XLEN-1:0] r_write_data_m;
  logic [XLEN-1:0] r_pc_plus4_m;

`ifdef EXEC_FORWARD_EN
  // FWD_MEM feeds back this stage's own registered result (one-behind producer).
  always_comb begin
    w_src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = r_alu_result_m;
      default: w_src_a = RD1_E;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_WB:  w_fwd_b = ResultW;
      FWD_MEM: w_fwd_b = r_alu_result_m;
      default: w_fwd_b = RD2_E;
    endcase
  end
`else
  // Hazard unit stalls instead; select ports stay for interface compatibility.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ForwardA_E, ForwardB_E, ResultW};
  assign w_src_a      = RD1_E;
  assign w_fwd_b      = RD2_E;
`endif

  assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

  alu u_alu (
    .SrcA       (w_src_a),
    .SrcB       (w_src_b),
    .ALUControl (ALUControlE),
    .Result     (w_alu_result),
    .Zero       (w_zero)
  );

  assign PCSrcE    = w_zero & BranchE;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 1'b0;
      r_rd_m         <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_pc_plus4_m   <= '0;
    end else begin
      r_reg_write_m  <= RegWriteE;
      r_mem_write_m  <= MemWriteE;
      r_result_src_m <= ResultSrcE;
      r_rd_m         <= RD_E;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_fwd_b;
      r_pc_plus4_m   <= PCPlus4E;
    end
  end

  assign RegWriteM  = r_reg_write_m;
  assign MemWriteM  = r_mem_write_m;
  assign ResultSrcM = r_result_src_m;
  assign RD_M       = r_rd_m;
  assign ALUResultM = r_alu_result_m;
  assign WriteDataM = r_write_data_m;
  assign PCPlus4M   = r_pc_plus4_m;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle; forwarding expectations follow EXEC_FORWARD_EN.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int n_checks = 0;
  int n_errors = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
    PCE = 0; PCPlus4E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
  endtask

  task automatic drive_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive_idle();
    ALUControlE = op; RD1_E = a; RD2_E = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    // Random inputs while held in reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
      ResultSrcE = 1'($urandom_range(0, 1)); RD1_E = $urandom; RD2_E = $urandom;
      RD_E = 5'($urandom_range(0, 31)); PCPlus4E = $urandom;
      ALUControlE = 3'($urandom_range(0, 7));
    end
    step();
    check("rst_regwrite", {31'b0, RegWriteM}, 32'h0);
    check("rst_memwrite", {31'b0, MemWriteM}, 32'h0);
    check("rst_resultsrc", {31'b0, ResultSrcM}, 32'h0);
    check("rst_rd", {27'b0, RD_M}, 32'h0);
    check("rst_alu", ALUResultM, 32'h0);
    check("rst_wdata", WriteDataM, 32'h0);
    check("rst_pc4", PCPlus4M, 32'h0);

    // Release and add 5+7
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    ALUControlE = 3'b000; RD1_E = 5; RD2_E = 7; RegWriteE = 1; RD_E = 5'd3;
    PCPlus4E = 32'h24; ResultSrcE = 1;
    step();
    check("add_result", ALUResultM, 32'd12);
    check("add_regwrite", {31'b0, RegWriteM}, 32'h1);
    check("add_rd", {27'b0, RD_M}, 32'd3);
    check("add_pc4", PCPlus4M, 32'h24);
    check("add_resultsrc", {31'b0, ResultSrcM}, 32'h1);

    // Dependent instruction one behind the add; B forwarded from writeback
    @(negedge clk);
    drive_idle();
    ForwardA_E = 2'b10; RD1_E = 0; Imm_Ext_E = 3; ALUSrcE = 1;
    ForwardB_E = 2'b01; ResultW = 9; RD2_E = 2;
    step();
`ifdef EXEC_FORWARD_EN
    check("fwd_mem_a", ALUResultM, 32'd15);
    check("fwd_wb_b", WriteDataM, 32'd9);
`else
    check("nofwd_a", ALUResultM, 32'd3);
    check("nofwd_b", WriteDataM, 32'd2);
`endif

    // Both operands from MEM: 15+15 when forwarding, else 1+2
    @(negedge clk);
    drive_idle();
    ForwardA_E = 2'b10; ForwardB_E = 2'b10; RD1_E = 1; RD2_E = 2;
    step();
`ifdef EXEC_FORWARD_EN
    check("fwd_both", ALUResultM, 32'd30);
`else
    check("fwd_both", ALUResultM, 32'd3);
`endif

    // Select 11 behaves like register-file operands
    @(negedge clk);
    drive_idle();
    ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 32'h10; RD2_E = 32'h20; ResultW = 32'hDEAD;
    step();
    check("fwd_11", ALUResultM, 32'h30);
    check("fwd_11_wd", WriteDataM, 32'h20);

    drive_alu(3'b001, 32'h0, 32'h1);          step(); check("sub_wrap", ALUResultM, 32'hFFFFFFFF);
    drive_alu(3'b000, 32'hFFFFFFFF, 32'h2);   step(); check("add_wrap", ALUResultM, 32'h1);
    drive_alu(3'b101, 32'hFFFFFFFF, 32'h1);   step(); check("slt_neg", ALUResultM, 32'h1);
    drive_alu(3'b101, 32'h1, 32'hFFFFFFFF);   step(); check("slt_pos", ALUResultM, 32'h0);
    drive_alu(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00); step(); check("and", ALUResultM, 32'h00F0_1200);
    drive_alu(3'b011, 32'hF000_0001, 32'h0000_0F10); step(); check("or", ALUResultM, 32'hF000_0F11);
    drive_alu(3'b111, 32'h5, 32'h7);          step(); check("op_111", ALUResultM, 32'h0);
    drive_alu(3'b100, 32'h5, 32'h7);          step(); check("op_100", ALUResultM, 32'h0);

    // Branch resolution, combinational in the same cycle
    @(negedge clk);
    drive_idle();
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 4; RD2_E = 4; PCE = 32'h100; Imm_Ext_E = 32'h10;
    #1;
    check("beq_taken", {31'b0, PCSrcE}, 32'h1);
    check("beq_target", PCTargetE, 32'h110);
    RD2_E = 5;
    #1;
    check("beq_not_taken", {31'b0, PCSrcE}, 32'h0);
    RD2_E = 4; BranchE = 0;
    #1;
    check("no_branch", {31'b0, PCSrcE}, 32'h0);
    PCE = 32'hFFFF_FFF8; Imm_Ext_E = 32'h10;
    #1;
    check("target_wrap", PCTargetE, 32'h8);

    // Immediate address vs store data
    @(negedge clk);
    drive_idle();
    ALUSrcE = 1; MemWriteE = 1; RD2_E = 32'hAA; Imm_Ext_E = 8; RD1_E = 32'h40;
    step();
    check("st_addr", ALUResultM, 32'h48);
    check("st_data", WriteDataM, 32'hAA);
    check("st_memwrite", {31'b0, MemWriteM}, 32'h1);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    drive_idle();
    RegWriteE = 1; MemWriteE = 1; RD1_E = 1; RD2_E = 1;
    step();
    check("pre_rst_regwrite", {31'b0, RegWriteM}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_regwrite", {31'b0, RegWriteM}, 32'h0);
    check("async_memwrite", {31'b0, MemWriteM}, 32'h0);
    check("async_alu", ALUResultM, 32'h0);

    // Release mid-stream: first capture on next posedge
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    RD1_E = 32'h100; RD2_E = 32'h23; RegWriteE = 1;
    #1;
    check("post_rel_hold", ALUResultM, 32'h0);
    step();
    check("post_rel_cap", ALUResultM, 32'h123);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
